bcd_scan_disp: RTL and testbench

- Downstream display stage for the 4-bit adder datapath.
- Accepts an 8-bit binary result over a valid/ready handshake and converts it sequentially to two BCD digits using shift-add-3 (double-dabble).
- Drives a time-multiplexed two-digit common-anode seven-segment display, so one shared segment bus replaces two dedicated digit buses.

---
 rtl/bcd_disp_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 16 +
 rtl/bcd_scan_disp.sv | 146 ++++++++++++++
 tb/tb_bcd_scan_disp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit BCD scanning display.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [0:9][6:0] DIGIT_SEG = {
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // One double-dabble step: correct each nibble >=5 by +3, then shift in the next binary bit.
  function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic msb);
    logic [11:0] t;
    t = bcd;
    for (int i = 0; i < 3; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[10:0], msb};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purpose: BCD digit to active-low seven-segment pattern; non-BCD codes decode to blank.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input digit.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = DIGIT_SEG[digit];
  end

endmodule

// File: rtl/bcd_scan_disp.sv
// Purpose: 8-bit binary to two-digit BCD (double-dabble) driving a scanned common-anode display; LEAD_ZERO_BLANK_EN blanks a zero tens digit.
// Latency: display regs update 9 cycles after the accepting edge, pins one cycle later.
// Backpressure: din_ready is low for the 9 cycles of a conversion; din_valid while busy is not acknowledged.
module bcd_scan_disp
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  state_t state, state_nxt;

  logic [7:0]  bin_sr;
  logic [11:0] bcd;
  logic [2:0]  bit_cnt;

  logic [3:0] tens, ones;
  logic       ovf;

  logic [SCAN_W-1:0] scan_cnt;
  logic              sel;
  logic              scan_wrap;

  logic [3:0] digit_mux;
  logic [6:0] dig_seg;
  logic [6:0] seg_nxt;
  logic [6:0] seg_q;
  logic [1:0] an_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = CONV;
      end
      CONV: begin
        if (bit_cnt == 3'd7) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A partial accumulator is never visible: the display regs change only in LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      tens    <= '0;
      ones    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            bin_sr  <= din;
            bcd     <= '0;
            bit_cnt <= '0;
          end
        end
        CONV: begin
          bcd     <= dabble_step(bcd, bin_sr[7]);
          bin_sr  <= {bin_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        LOAD: begin
          if (bcd[11:8] != 4'd0) begin
            ovf <= 1'b1;
          end else begin
            ovf  <= 1'b0;
            tens <= bcd[7:4];
            ones <= bcd[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      sel      <= ~sel;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign digit_mux = sel ? tens : ones;

  seg7_decode u_dec (
    .digit (digit_mux),
    .seg   (dig_seg)
  );

  always_comb begin
    seg_nxt = dig_seg;
    if (ovf)                               seg_nxt = SEG_DASH;
    else if (LZB && sel && tens == 4'd0)   seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= DIGIT_SEG[0];
      an_q  <= 2'b10;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= sel ? 2'b01 : 2'b10;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_scan_disp.sv
// Scoreboard bench for bcd_scan_disp: stimulus queues expected handshakes and digit patterns,
// independent monitors compare them when the DUT handshakes and scans.
module tb_bcd_scan_disp;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] TZ = 7'h7F;
`else
  localparam logic [6:0] TZ = S0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  bcd_scan_disp #(.SCAN_DIV(SCAN_DIV), .SCAN_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_eight = 0;

  typedef struct { logic [7:0] val; bit abort; } hs_t;
  typedef struct { logic [6:0] t; logic [6:0] o; } disp_t;
  typedef struct { logic [1:0] an; int len; } run_t;

  hs_t   hs_q[$];
  disp_t disp_q[$];
  int    start_q[$];
  run_t  scan_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_val(input logic [7:0] v, input bit ab, input logic [6:0] t, input logic [6:0] o);
    hs_t h;
    disp_t d;
    h.val = v; h.abort = ab;
    d.t = t; d.o = o;
    hs_q.push_back(h);
    disp_q.push_back(d);
  endtask

  task automatic send(input logic [7:0] v);
    bit done;
    done = 0;
    din = v;
    din_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (din_ready) begin
        @(posedge clk);
        #1;
        done = 1;
        break;
      end
    end
    if (!done) check("send_timeout", 0, 1);
    din_valid = 1'b0;
  endtask

  // A segment bus of all-on only appears for an "88" that must never reach the pins.
  always @(negedge clk) if (seg === 7'b0000000) n_eight++;

  // Handshake monitor: accepted value, busy length, abort on reset.
  initial begin
    bit skip;
    skip = 0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 0;
      if (rst_n && din_valid && din_ready) begin
        logic [7:0] got;
        int n_edge, busy;
        bit aborted;
        hs_t e;
        got = din;
        n_edge = cyc + 1;
        @(posedge clk);
        if (hs_q.size() == 0) begin
          check("hs_unexpected", 0, 1);
          continue;
        end
        e = hs_q.pop_front();
        check("hs_value", got, e.val);
        busy = 0;
        aborted = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (!rst_n) begin aborted = 1; break; end
          if (din_ready) break;
          busy++;
        end
        check("hs_abort", aborted, e.abort);
        if (aborted) begin
          @(negedge clk);
          check("rst_ready", din_ready, 1);
          start_q.push_back(cyc);
        end else begin
          check("busy_cycles", busy, 9);
          start_q.push_back(n_edge + 10);
        end
        skip = 1;
      end
    end
  end

  // Display monitor: one full scan period per result, capturing each digit.
  initial begin
    forever begin
      int st;
      disp_t e;
      logic [6:0] got_t, got_o;
      while (start_q.size() == 0) @(negedge clk);
      st = start_q.pop_front();
      if (disp_q.size() == 0) begin
        check("disp_unexpected", 0, 1);
        continue;
      end
      e = disp_q.pop_front();
      for (int k = 0; k < 100 && cyc < st; k++) @(negedge clk);
      got_t = 7'bx;
      got_o = 7'bx;
      for (int i = 0; i < 2 * SCAN_DIV; i++) begin
        if (an === 2'b01) got_t = seg;
        if (an === 2'b10) got_o = seg;
        @(negedge clk);
      end
      check("seg_tens", got_t, e.t);
      check("seg_ones", got_o, e.o);
    end
  end

  // Scan monitor: reset state, then the first digit-select runs after reset.
  initial begin
    logic [1:0] cur;
    int len;
    @(posedge rst_n);
    @(negedge clk);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, S0);
    check("rst_dp", dp, 1);
    check("rst_din_ready", din_ready, 1);
    cur = an;
    len = 1;
    while (scan_q.size() > 0) begin
      run_t r;
      r = scan_q.pop_front();
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (an !== cur) break;
        len++;
      end
      check("scan_run_an", cur, r.an);
      check("scan_run_len", len, r.len);
      cur = an;
      len = 1;
    end
  end

  initial begin
    // Counter is 0 at the reset edge, so the first ones period shows one extra cycle of the reset value.
    scan_q.push_back('{an: 2'b10, len: 5});
    scan_q.push_back('{an: 2'b01, len: 4});
    scan_q.push_back('{an: 2'b10, len: 4});
    scan_q.push_back('{an: 2'b01, len: 4});
    scan_q.push_back('{an: 2'b10, len: 4});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    expect_val(8'd30, 0, S3, S0);  send(8'd30);  repeat (20) @(posedge clk); #1;
    expect_val(8'd99, 0, S9, S9);  send(8'd99);  repeat (20) @(posedge clk); #1;
    expect_val(8'd100, 0, SD, SD); send(8'd100); repeat (20) @(posedge clk); #1;
    expect_val(8'd255, 0, SD, SD); send(8'd255); repeat (20) @(posedge clk); #1;
    expect_val(8'd7, 0, TZ, S7);   send(8'd7);   repeat (20) @(posedge clk); #1;

    expect_val(8'd12, 0, S1, S2);
    expect_val(8'd45, 0, S4, S5);
    send(8'd12);
    send(8'd45);
    repeat (20) @(posedge clk); #1;

    expect_val(8'd88, 1, TZ, S0);
    send(8'd88);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;

    expect_val(8'd0, 0, TZ, S0);   send(8'd0);
    repeat (30) @(posedge clk); #1;

    check("queues_drained", hs_q.size() + disp_q.size() + start_q.size(), 0);
    check("never_all_on", n_eight, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
